// File: rtl/ldpc_3gpp_enc_p1_ctrl_pkg.sv
// Shared types for the 3GPP LDPC encoder parity controllers.
// Holds the read strobe bundle, the lifting-size type and the controller state enum.
package ldpc_3gpp_enc_p1_ctrl_pkg;

  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
  } strb_t;

  // lifting size Zc, up to 384
  typedef logic [8:0] hb_zc_t;

  typedef enum logic [2:0] {
    CTRL_IDLE  = 3'd0,
    CTRL_WRITE = 3'd1,
    CTRL_READ  = 3'd2,
    CTRL_DRAIN = 3'd3,
    CTRL_DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/ldpc_3gpp_enc_p1_ctrl.sv
// Sequencer for the invPsi multiply stage: counts the 4W input words, sweeps the
// 4x4 invPsi matrix (row, word, column), waits for the p1 end-of-frame, reports done.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for iwstart&iwrite
// WRITE | counting accepted writes up to 4W
// READ  | 16W-cycle read sweep, r 0..3 / w 0..W-1 / c 0..3
// DRAIN | waiting for ip1_val&ip1_eof
// DONE  | one-cycle odone, then IDLE
module ldpc_3gpp_enc_p1_ctrl
  import ldpc_3gpp_enc_p1_ctrl_pkg::*;
#(
  parameter int pWCNT_W = 8
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic [pWCNT_W-1:0] iword_num,
  input  logic               ibypass,
  input  logic               iwrite,
  input  logic               iwstart,
  input  logic               ip1_val,
  input  logic               ip1_eof,
  output logic               oread,
  output logic               orstart,
  output logic               orval,
  output strb_t              orstrb,
  output logic [1:0]         orow,
  output logic [1:0]         ocol,
  output logic               obusy,
  output logic               odone
);

  localparam int cWCNT_W = pWCNT_W + 2;

  ctrl_state_t        state, state_nxt;
  logic [cWCNT_W-1:0] wcnt, wcnt_nxt, wcnt_inc;
  logic [pWCNT_W-1:0] word_num, word_num_nxt, word_num_in;
  logic [pWCNT_W-1:0] wrd, wrd_nxt;
  logic               bypass, bypass_nxt;
  logic [1:0]         row, row_nxt, col, col_nxt;
  logic               read_nxt, done_nxt, start, last_read;
  strb_t              strb_nxt;

  assign start       = iwstart & iwrite;
  assign word_num_in = (iword_num == '0) ? pWCNT_W'(1) : iword_num;
  assign wcnt_inc    = wcnt + cWCNT_W'(1);
  assign last_read   = (row == 2'd3) && (col == 2'd3) && (wrd == word_num - pWCNT_W'(1));

  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    word_num_nxt = word_num;
    bypass_nxt   = bypass;
    row_nxt      = row;
    wrd_nxt      = wrd;
    col_nxt      = col;
    read_nxt     = 1'b0;
    done_nxt     = 1'b0;
    strb_nxt     = '0;

    if (start) begin
      // a new block start aborts whatever is in flight
      state_nxt    = CTRL_WRITE;
      wcnt_nxt     = cWCNT_W'(1);
      word_num_nxt = word_num_in;
      bypass_nxt   = ibypass;
      row_nxt      = '0;
      wrd_nxt      = '0;
      col_nxt      = '0;
    end else begin
      case (state)
        CTRL_WRITE: begin
          if (iwrite) begin
            wcnt_nxt = wcnt_inc;
            if (wcnt_inc == {word_num, 2'b00}) begin
              if (bypass) begin
                state_nxt = CTRL_DONE;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = CTRL_READ;
                read_nxt  = 1'b1;
                row_nxt   = '0;
                wrd_nxt   = '0;
                col_nxt   = '0;
              end
            end
          end
        end
        CTRL_READ: begin
          if (last_read) begin
            state_nxt = CTRL_DRAIN;
          end else begin
            read_nxt = 1'b1;
            col_nxt  = col + 2'd1;
            if (col == 2'd3) begin
              if (wrd == word_num - pWCNT_W'(1)) begin
                wrd_nxt = '0;
                row_nxt = row + 2'd1;
              end else begin
                wrd_nxt = wrd + pWCNT_W'(1);
              end
            end
          end
        end
        CTRL_DRAIN: begin
          if (ip1_val && ip1_eof) begin
            state_nxt = CTRL_DONE;
            done_nxt  = 1'b1;
          end
        end
        CTRL_DONE: state_nxt = CTRL_IDLE;
        default:   state_nxt = CTRL_IDLE;
      endcase
    end

    // strobes describe the word the read counters will point at next cycle
    if (read_nxt) begin
      strb_nxt.sop = (col_nxt == 2'd0);
      strb_nxt.eop = (col_nxt == 2'd3);
      strb_nxt.sof = (row_nxt == 2'd0) && (wrd_nxt == '0) && (col_nxt == 2'd0);
      strb_nxt.eof = (row_nxt == 2'd3) && (col_nxt == 2'd3) &&
                     (wrd_nxt == word_num_nxt - pWCNT_W'(1));
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state    <= CTRL_IDLE;
      wcnt     <= '0;
      word_num <= pWCNT_W'(1);
      bypass   <= 1'b0;
      row      <= '0;
      wrd      <= '0;
      col      <= '0;
      oread    <= 1'b0;
      orval    <= 1'b0;
      orstart  <= 1'b0;
      orstrb   <= '0;
      obusy    <= 1'b0;
      odone    <= 1'b0;
    end else if (iclkena) begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      word_num <= word_num_nxt;
      bypass   <= bypass_nxt;
      row      <= row_nxt;
      wrd      <= wrd_nxt;
      col      <= col_nxt;
      oread    <= read_nxt;
      orval    <= read_nxt;
      orstart  <= strb_nxt.sof;
      orstrb   <= strb_nxt;
      obusy    <= (state_nxt != CTRL_IDLE);
      odone    <= done_nxt;
    end
  end

  assign orow = row;
  assign ocol = col;

endmodule
